// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: 2-FF synchroniser, stability counter, level and edge pulses.
// Define DEBOUNCE_LONG_PRESS_EN to add a per-channel long-press (HOLD) detector.
module debounce_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000,
  parameter int LONG_W     = 24,
  parameter int LONG_CNT   = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] pb_db,
  output logic [N_CH-1:0] pb_rise,
  output logic [N_CH-1:0] pb_fall,
  output logic [N_CH-1:0] hold
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

  // Elaboration-time sanity check of the counter ranges.
  if (N_CH < 1 || STABLE_CNT < 1 || STABLE_CNT > (2 ** CNT_W) - 1 ||
      LONG_CNT < 1 || LONG_CNT > (2 ** LONG_W) - 1) begin : g_bad_params
    $error("debounce_multi: parameter out of range");
  end

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             db_q;
    logic             rise_q;
    logic             fall_q;
    logic             accept;

    assign accept = (sync2[ch] != db_q) && (cnt == STABLE_LAST);

    // Any cycle where the synchronised input matches the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync2[ch] == db_q) begin
          cnt <= '0;
        end else if (accept) begin
          cnt    <= '0;
          db_q   <= sync2[ch];
          rise_q <= sync2[ch];
          fall_q <= ~sync2[ch];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign pb_db[ch]   = db_q;
    assign pb_rise[ch] = rise_q;
    assign pb_fall[ch] = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);
    logic [LONG_W-1:0] hcnt;
    logic              hold_q;

    // Counter saturates at LONG_LAST; HOLD asserts LONG_CNT cycles after the level rose.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt   <= '0;
        hold_q <= 1'b0;
      end else if (accept && !sync2[ch]) begin
        hcnt   <= '0;
        hold_q <= 1'b0;
      end else if (!db_q || accept) begin
        hcnt <= '0;
      end else if (hcnt == LONG_LAST) begin
        hold_q <= 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end

    assign hold[ch] = hold_q;
`endif
  end

`ifndef DEBOUNCE_LONG_PRESS_EN
  assign hold = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised and directed bench for debounce_multi (N_CH=2, STABLE_CNT=8, LONG_CNT=32).
// Reference model works on a window of the last STABLE_CNT synchronised samples per channel.
`timescale 1ns/1ps
module tb_debounce_multi;
  localparam int N  = 2;
  localparam int ST = 8;
  localparam int LC = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pb = 2'b00;
  logic [1:0] pb_db, pb_rise, pb_fall, hold;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_db[N], m_rise[N], m_fall[N], m_hold[N];
  int m_run[N];
  bit hist[N][$];
  bit win[N][$];

  always #1 clk = ~clk;

  debounce_multi #(
    .N_CH(N), .CNT_W(16), .STABLE_CNT(ST), .LONG_W(8), .LONG_CNT(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb(pb),
    .pb_db(pb_db), .pb_rise(pb_rise), .pb_fall(pb_fall), .hold(hold)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_db[ch] = 0; m_rise[ch] = 0; m_fall[ch] = 0; m_hold[ch] = 0; m_run[ch] = 0;
      hist[ch].delete();
      hist[ch].push_back(1'b0);
      hist[ch].push_back(1'b0);
      win[ch].delete();
    end
  endfunction

  // Advance one clock; model sees pb as it was at the edge, outputs sampled at the falling edge.
  task automatic step();
    bit seen, flip;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        seen = hist[ch][0];
        hist[ch].push_back(pb[ch]);
        void'(hist[ch].pop_front());
        win[ch].push_back(seen);
        if (win[ch].size() > ST) void'(win[ch].pop_front());
        flip = (win[ch].size() == ST);
        foreach (win[ch][k]) if (win[ch][k] == m_db[ch]) flip = 0;
        m_rise[ch] = 0;
        m_fall[ch] = 0;
        if (flip) begin
          m_db[ch] = !m_db[ch];
          m_rise[ch] = m_db[ch];
          m_fall[ch] = !m_db[ch];
          win[ch].delete();
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (m_fall[ch]) begin
          m_hold[ch] = 0; m_run[ch] = 0;
        end else if (m_rise[ch]) begin
          m_run[ch] = 0;
        end else if (m_db[ch]) begin
          m_run[ch]++;
          if (m_run[ch] >= LC) m_hold[ch] = 1;
        end
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat = 0, r0 = 0, r1 = 0, f = 0;
    rst_n = 0; pb = 2'b11; model_reset();
    repeat (3) step();
    n_checks++;
    if ({pb_db, pb_rise, pb_fall, hold} !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 00", {pb_db, pb_rise, pb_fall, hold});
    end
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      r0 += pb_rise[0]; r1 += pb_rise[1]; f += pb_fall[0] + pb_fall[1];
      if (pb_db == 2'b11 && lat == 0) lat = i + 1;
    end
    n_checks++;
    if (lat != ST + 2) begin n_fail++; $display("FAIL reset_release_latency: got %0d expected %0d", lat, ST + 2); end
    n_checks++;
    if (r0 != 1 || r1 != 1) begin n_fail++; $display("FAIL reset_release_rise: got %0d/%0d expected 1/1", r0, r1); end
    n_checks++;
    if (f != 0) begin n_fail++; $display("FAIL reset_release_fall: got %0d expected 0", f); end
  endtask

  task automatic test_fall();
    int lat = 0, falls = 0;
    bit pulse_at_change = 0, pulse_after = 0;
    pb[0] = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      falls += pb_fall[0];
      if (lat != 0 && i == lat) pulse_after = pb_fall[0];
      if (pb_db[0] == 0 && lat == 0) begin
        lat = i + 1;
        pulse_at_change = pb_fall[0] && !pb_rise[0];
      end
    end
    n_checks++;
    if (lat != ST + 2) begin n_fail++; $display("FAIL fall_latency: got %0d expected %0d", lat, ST + 2); end
    n_checks++;
    if (!pulse_at_change) begin n_fail++; $display("FAIL fall_pulse_coincident: got 0 expected 1"); end
    n_checks++;
    if (falls != 1 || pulse_after) begin
      n_fail++; $display("FAIL fall_pulse_width: got count %0d after %0d expected 1 and 0", falls, pulse_after);
    end
  endtask

  task automatic test_bounce();
    int lat = 0, rises = 0, changed = 0;
    for (int seg = 0; seg < 10; seg++) begin
      pb[0] = (seg % 2 == 0);
      repeat (3) begin
        step();
        changed += pb_db[0] + pb_rise[0] + pb_fall[0];
      end
    end
    n_checks++;
    if (changed != 0) begin n_fail++; $display("FAIL bounce_rejected: got %0d events expected 0", changed); end
    pb[0] = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      rises += pb_rise[0];
      if (pb_db[0] && lat == 0) lat = i + 1;
    end
    n_checks++;
    if (lat != ST + 2) begin n_fail++; $display("FAIL bounce_settle_latency: got %0d expected %0d", lat, ST + 2); end
    n_checks++;
    if (rises != 1) begin n_fail++; $display("FAIL bounce_single_rise: got %0d expected 1", rises); end
  endtask

  task automatic test_short_pulse();
    int ev = 0, rises = 0, falls = 0, high = 0, ch0_dist = 0;
    bit db0;
    pb[1] = 0;
    repeat (15) step();
    db0 = pb_db[0];
    for (int i = 0; i < 45; i++) begin
      pb[1] = (i < ST - 1);
      step();
      ev += pb_db[1] + pb_rise[1] + pb_fall[1];
    end
    n_checks++;
    if (ev != 0) begin n_fail++; $display("FAIL short_pulse_rejected: got %0d events expected 0", ev); end
    for (int i = 0; i < 45; i++) begin
      pb[1] = (i < ST);
      step();
      high += pb_db[1]; rises += pb_rise[1]; falls += pb_fall[1];
      if (pb_db[0] != db0 || pb_rise[0] || pb_fall[0]) ch0_dist++;
    end
    n_checks++;
    if (high == 0 || pb_db[1] !== 1'b0) begin
      n_fail++; $display("FAIL min_pulse_level: got high %0d final %0d expected >0 and 0", high, pb_db[1]);
    end
    n_checks++;
    if (rises != 1 || falls != 1) begin
      n_fail++; $display("FAIL min_pulse_edges: got %0d/%0d expected 1/1", rises, falls);
    end
    n_checks++;
    if (ch0_dist != 0) begin n_fail++; $display("FAIL channel_isolation: got %0d events expected 0", ch0_dist); end
  endtask

  task automatic test_reset_mid();
    int lat = 0, rises = 0;
    pb = 2'b10;
    repeat (15) step();
    pb[0] = 1;
    repeat (5) step();
    rst_n = 0;
    #0.2;
    n_checks++;
    if ({pb_db, pb_rise, pb_fall, hold} !== 8'h00) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h expected 00", {pb_db, pb_rise, pb_fall, hold});
    end
    model_reset();
    repeat (2) step();
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      rises += pb_rise[0];
      if (pb_db[0] && lat == 0) lat = i + 1;
    end
    n_checks++;
    if (lat != ST + 2) begin n_fail++; $display("FAIL reset_mid_latency: got %0d expected %0d", lat, ST + 2); end
    n_checks++;
    if (rises != 1) begin n_fail++; $display("FAIL reset_mid_rise: got %0d expected 1", rises); end
  endtask

  task automatic test_hold();
    int hl = 0, n = 0;
    bit prev_hold = 0, hold_at_fall = 1, seen_fall = 0;
    pb[0] = 0;
    repeat (15) step();
    pb[0] = 1;
    while (!pb_db[0] && n < 20) begin step(); n++; end
    n_checks++;
    if (!pb_db[0]) begin n_fail++; $display("FAIL hold_setup_rise: got 0 expected 1"); end
`ifdef DEBOUNCE_LONG_PRESS_EN
    for (int i = 0; i < 60; i++) begin
      step();
      if (hold[0] && hl == 0) hl = i + 1;
    end
    n_checks++;
    if (hl != LC) begin n_fail++; $display("FAIL hold_latency: got %0d expected %0d", hl, LC); end
    pb[0] = 0;
    for (int i = 0; i < 20; i++) begin
      prev_hold = hold[0];
      step();
      if (!pb_db[0] && !seen_fall) begin seen_fall = 1; hold_at_fall = hold[0] || !prev_hold; end
    end
    n_checks++;
    if (!seen_fall || hold_at_fall) begin
      n_fail++; $display("FAIL hold_clear_on_fall: got fall %0d hold_err %0d expected 1 and 0", seen_fall, hold_at_fall);
    end
`else
    for (int i = 0; i < 60; i++) begin
      step();
      hl += hold[0] + hold[1];
    end
    pb[0] = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      hl += hold[0] + hold[1];
      seen_fall |= !pb_db[0];
    end
    n_checks++;
    if (hl != 0 || !seen_fall) begin
      n_fail++; $display("FAIL hold_tied_low: got %0d highs fall %0d expected 0 and 1", hl, seen_fall);
    end
`endif
  endtask

  task automatic test_random();
    int left[N];
    for (int ch = 0; ch < N; ch++) left[ch] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (left[ch] == 0) begin
          pb[ch] = $urandom_range(0, 1);
          left[ch] = (cyc % 500 < 100) ? $urandom_range(40, 60) : $urandom_range(1, 20);
        end
        left[ch]--;
      end
      step();
      for (int ch = 0; ch < N; ch++) begin
        n_checks++;
        if (pb_db[ch] !== m_db[ch] || pb_rise[ch] !== m_rise[ch] ||
            pb_fall[ch] !== m_fall[ch] || hold[ch] !== m_hold[ch]) begin
          n_fail++;
          $display("FAIL random_ch%0d cyc %0d: got db%0d r%0d f%0d h%0d expected db%0d r%0d f%0d h%0d",
                   ch, cyc, pb_db[ch], pb_rise[ch], pb_fall[ch], hold[ch],
                   m_db[ch], m_rise[ch], m_fall[ch], m_hold[ch]);
        end
        n_checks++;
        if (pb_rise[ch] && pb_fall[ch]) begin
          n_fail++; $display("FAIL random_rise_fall_exclusive ch%0d: got 11 expected not both", ch);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_bounce();
    test_short_pulse();
    test_reset_mid();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
